ff_pipe_processor: RTL and testbench
====================================

FF_PIPE_PROCESSOR -- requirements
Module: ff_pipe_processor

Interface
REQ-001 SHALL have parameter width, default 16, total fixed-point word bits.
REQ-002 SHALL have parameter int_bits, default 5, integer bits (sign excluded).
REQ-003 SHALL have parameter frac_bits, default 10, fractional bits.
REQ-004 SHALL have parameter z, default 4, products per beat (power of 2).
REQ-005 SHALL have parameter fi, default 8, neuron fan-in; fi = z*BEATS, BEATS power of 2 and >= 1.
REQ-006 SHALL have parameter n, default 8, neurons per layer (out_last period).
REQ-007 SHALL have ports, in order:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid&&in_ready
- act_in_package  in  width*z  z signed activations, word k at [width*(k+1)-1:width*k]
- wt_package  in  width*z  z signed weights, same packing
- bias  in  width  signed bias, sampled on first beat of a neuron only
- out_valid  out  1  result held
- out_ready  in  1  result consumed when out_valid&&out_ready
- act_out  out  width  activation value
- adot_out  out  width  activation derivative
- out_sat  out  1  pre-activation sum was saturated
- out_last  out  1  result is neuron n-1 of the layer

Function
REQ-008 SHALL form each product as full 2*width signed product, arithmetic shift right frac_bits, saturate to signed width.
REQ-009 SHALL sum the z products per beat in a tree of width ACC = width+$clog2(fi)+1, sign-extended, no intermediate truncation.
REQ-010 SHALL keep beat counter 0..BEATS-1: beat 0 loads acc = sext(bias)+tree_sum; later beats acc += tree_sum; counter wraps to 0 after BEATS-1.
REQ-011 SHALL on the accepted last beat load stage S with s = acc saturated to signed width (max 0x7FF..F, min 0x800..0) and sat flag = saturation occurred.
REQ-012 SHALL move stage S into output stage O when O is empty or out_ready=1; O produces act_out/adot_out via registered lookup.
REQ-013 SHALL assert out_valid exactly 2 cycles after the last-beat accept when out_ready stays 1 (latency 2).
REQ-014 SHALL drive in_ready = !(s_valid && out_valid && !out_ready); beats other than the last are still blocked by this rule.
REQ-015 SHALL hold act_out, adot_out, out_sat, out_last stable while out_valid && !out_ready.
REQ-016 SHALL sustain one neuron per BEATS cycles with in_valid and out_ready held high.
REQ-017 SHALL keep neuron counter 0..n-1, increment on each out_valid&&out_ready, out_last=1 when counter=n-1, wrap to 0.
REQ-018 SHALL, when an output is consumed and a last beat is accepted in the same cycle, perform both with no bubble and no loss.

Reset
REQ-019 SHALL on reset_n=0 at a clock edge clear beat counter, neuron counter, acc, s_valid, out_valid, act_out, adot_out, out_sat, out_last to 0.
REQ-020 SHALL drive in_ready=0 while reset_n=0 and in_ready=1 on the first cycle after release.
REQ-021 SHALL discard a partially accumulated neuron on reset; next accepted beat is beat 0.

Configuration
REQ-022 SHALL use macro ACT_RELU_EN: defined -> act_out = max(0,s), adot_out = 1.0 (1<<frac_bits) if s>0 else 0; undefined -> sigmoid and sigmoid-prime table lookup on s.
REQ-023 SHALL keep latency, handshake and out_sat identical in both configurations.

Structure
REQ-024 SHALL place default width/int_bits/frac_bits and the ACC width function in shared package dnn_params_pkg.
REQ-025 SHALL implement stage O lookup in one sub-module act_unit (clk, enable, s, act, adot), both tables gated by enable.

Verification (width=16, frac_bits=10, z=4, fi=8, sigmoid unless noted)
REQ-026 SHALL cover: act=0x0400, wt=0, bias=0, 2 beats -> act_out=0x0200, adot_out=0x0100, out_valid 2 cycles after beat 2, out_sat=0.
REQ-027 SHALL cover: act=0x0400, wt=0x7FFF all 8, bias=0x7FFF -> s=0x7FFF, out_sat=1; wt=0x8000 -> s=0x8000, out_sat=1.
REQ-028 SHALL cover: out_ready=0 for 10 cycles over 3 neurons -> in_ready falls once S and O full, outputs stable, no neuron lost or duplicated.
REQ-029 SHALL cover: beat 0 accepted, reset_n=0 one cycle, then clean neuron -> result equals the clean neuron alone.
REQ-030 SHALL cover: 16 back-to-back neurons -> out_last=1 on outputs 8 and 16 only, one output per 2 cycles.
REQ-031 SHALL cover (ACT_RELU_EN): products 0, bias=0xFC00 -> act_out=0, adot_out=0; bias=0x0800 -> act_out=0x0800, adot_out=0x0400.

Source files
------------

// File: rtl/dnn_params_pkg.sv
// Shared fixed-point defaults for the DNN datapath blocks.
// Contents:
//   DEF_WIDTH / DEF_INT_BITS / DEF_FRAC_BITS : default word format (sign + int + frac)
//   acc_width(width, fi)                     : accumulator width that holds a full
//                                              fan-in of saturated products plus bias
//                                              with no overflow
package dnn_params_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_INT_BITS  = 5;
  localparam int DEF_FRAC_BITS = 10;

  // One growth bit per doubling of the fan-in, plus one for the bias term.
  function automatic int acc_width(input int width, input int fi);
    return width + $clog2(fi) + 1;
  endfunction

endpackage

// File: rtl/act_unit.sv
// Registered activation stage: maps a saturated pre-activation s to the
// activation value and its derivative, both captured only when enable is high.
// Build option: ACT_RELU_EN
//   defined   -> act = max(0, s), adot = 1.0 when s > 0 else 0
//   undefined -> sigmoid from a 4-segment slope/offset table on |s| (mirrored
//                for negative s), derivative taken as act * (1 - act)
// Ports:
//   clk    : clock, rising edge
//   enable : capture strobe
//   s      : signed fixed-point pre-activation
//   act    : registered activation
//   adot   : registered activation derivative
module act_unit
  import dnn_params_pkg::*;
#(
  parameter int width     = DEF_WIDTH,
  parameter int frac_bits = DEF_FRAC_BITS
) (
  input  logic             clk,
  input  logic             enable,
  input  logic [width-1:0] s,
  output logic [width-1:0] act,
  output logic [width-1:0] adot
);

  // Headroom so the table constants (up to 5.0) never wrap.
  localparam int MW    = width + 4;
  localparam int ONE_I = 1 << frac_bits;
  localparam logic [MW-1:0] ONE = MW'(ONE_I);

  logic [width-1:0] act_d, adot_d;

`ifdef ACT_RELU_EN

  always_comb begin
    act_d  = '0;
    adot_d = '0;
    if ($signed(s) > 0) begin
      act_d  = s;
      adot_d = ONE[width-1:0];
    end
  end

`else

  // Segment table: breakpoints 1.0, 2.375, 5.0; slopes 1/4, 1/8, 1/32, 0.
  localparam logic [MW-1:0] T1 = MW'(ONE_I);
  localparam logic [MW-1:0] T2 = MW'((19 * ONE_I) / 8);
  localparam logic [MW-1:0] T3 = MW'(5 * ONE_I);
  localparam logic [MW-1:0] O0 = MW'(ONE_I / 2);
  localparam logic [MW-1:0] O1 = MW'((5 * ONE_I) / 8);
  localparam logic [MW-1:0] O2 = MW'((27 * ONE_I) / 32);

  logic [width-1:0]  neg_s;
  logic [MW-1:0]     mag, y_pos, y;
  logic [2*MW-1:0]   pr, pr_shr;
  logic              unused_pr;

  always_comb begin
    // Two's-complement negate at word width so -min maps to +2^(width-1).
    neg_s = ~s + 1'b1;
    mag   = {4'b0000, (s[width-1] ? neg_s : s)};
    if (mag >= T3)      y_pos = ONE;
    else if (mag >= T2) y_pos = (mag >> 5) + O2;
    else if (mag >= T1) y_pos = (mag >> 3) + O1;
    else                y_pos = (mag >> 2) + O0;
    // sigmoid(-x) = 1 - sigmoid(x)
    y      = s[width-1] ? (ONE - y_pos) : y_pos;
    pr     = y * (ONE - y);
    pr_shr = pr >> frac_bits;
    act_d  = y[width-1:0];
    adot_d = pr_shr[width-1:0];
  end

  // y <= 1.0 so the product upper bits are always zero.
  assign unused_pr = ^{pr_shr[2*MW-1:width], y[MW-1:width]};

`endif

  always_ff @(posedge clk) begin
    if (enable) begin
      act  <= act_d;
      adot <= adot_d;
    end
  end

endmodule

// File: rtl/ff_pipe_processor_mul.sv
// One multiplier lane of the neuron datapath.
// Forms the full 2*width signed product, rescales it by an arithmetic shift of
// frac_bits, and saturates the result back to a signed width-bit word.
// Ports:
//   a, b : signed fixed-point operands
//   p    : saturated fixed-point product
module ff_pipe_processor_mul #(
  parameter int width     = 16,
  parameter int frac_bits = 10
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] p
);

  localparam int PW = 2 * width;
  localparam logic signed [PW-1:0] PMAX = {{(width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN = ~PMAX;

  logic signed [PW-1:0] prod, shr;

  always_comb begin
    prod = $signed(a) * $signed(b);
    shr  = prod >>> frac_bits;
    if (shr > PMAX)      p = PMAX[width-1:0];
    else if (shr < PMIN) p = PMIN[width-1:0];
    else                 p = shr[width-1:0];
  end

endmodule

// File: rtl/ff_pipe_processor.sv
// Streaming fully-connected neuron processor.
// Each beat delivers z activation/weight pairs; BEATS = fi/z beats form one
// neuron. Products are saturated, summed exactly, accumulated with the bias
// (taken on beat 0), saturated to a word in stage S, then passed through the
// activation lookup in stage O. Latency from last-beat accept to out_valid is 2.
// Build option: ACT_RELU_EN selects ReLU instead of sigmoid in act_unit.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   in_valid / in_ready   : beat handshake
//   act_in_package        : z signed activations, word k at [width*(k+1)-1:width*k]
//   wt_package            : z signed weights, same packing
//   bias                  : signed bias, used on beat 0 only
//   out_valid / out_ready : result handshake
//   act_out, adot_out     : activation and derivative
//   out_sat               : pre-activation sum was clipped
//   out_last              : result is neuron n-1 of the layer
module ff_pipe_processor
  import dnn_params_pkg::*;
#(
  parameter int width     = DEF_WIDTH,
  parameter int int_bits  = DEF_INT_BITS,
  parameter int frac_bits = DEF_FRAC_BITS,
  parameter int z         = 4,
  parameter int fi        = 8,
  parameter int n         = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [width*z-1:0] act_in_package,
  input  logic [width*z-1:0] wt_package,
  input  logic [width-1:0]   bias,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [width-1:0]   act_out,
  output logic [width-1:0]   adot_out,
  output logic               out_sat,
  output logic               out_last
);

  localparam int BEATS = fi / z;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NW    = (n > 1) ? $clog2(n) : 1;
  localparam int ACC   = acc_width(width, fi);
  localparam int XW    = ACC - width;

  localparam logic signed [ACC-1:0] SMAX = {{(XW+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [ACC-1:0] SMIN = ~SMAX;

  generate
    if ((width != 1 + int_bits + frac_bits) || (BEATS * z != fi) || (BEATS < 1)) begin : g_cfg_bad
      $error("ff_pipe_processor: inconsistent word format or fan-in");
    end
  endgenerate

  typedef struct packed {
    logic             sat;
    logic [width-1:0] s;
  } s_stage_t;

  // ---------------- product lanes ----------------
  logic [z-1:0][width-1:0] prod;

  genvar k;
  generate
    for (k = 0; k < z; k++) begin : g_lane
      ff_pipe_processor_mul #(.width(width), .frac_bits(frac_bits)) u_mul (
        .a (act_in_package[width*k +: width]),
        .b (wt_package[width*k +: width]),
        .p (prod[k])
      );
    end
  endgenerate

  // Exact sum: every product is sign-extended to ACC before adding.
  logic signed [ACC-1:0] tree_sum, acc, acc_next;

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < z; i++)
      tree_sum = tree_sum + {{XW{prod[i][width-1]}}, prod[i]};
  end

  // ---------------- accumulator ----------------
  logic [BW-1:0] beat_cnt;
  logic          accept, last_beat, o_load, s_valid;
  s_stage_t      s_q, s_d;

  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign acc_next  = ((beat_cnt == '0) ? {{XW{bias[width-1]}}, bias} : acc) + tree_sum;

  always_comb begin
    s_d.sat = 1'b1;
    if (acc_next > SMAX)      s_d.s = SMAX[width-1:0];
    else if (acc_next < SMIN) s_d.s = SMIN[width-1:0];
    else begin
      s_d.s   = acc_next[width-1:0];
      s_d.sat = 1'b0;
    end
  end

  // Only a full S stage behind a stalled O stage blocks input, including
  // non-last beats, so a beat never has to be replayed.
  assign in_ready = reset_n && !(s_valid && out_valid && !out_ready);
  assign o_load   = s_valid && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      beat_cnt <= '0;
      acc      <= '0;
    end else if (accept) begin
      acc      <= acc_next;
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // ---------------- stages S and O ----------------
  logic          o_sat;
  logic [NW-1:0] nrn_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_valid   <= 1'b0;
      s_q       <= '0;
      out_valid <= 1'b0;
      o_sat     <= 1'b0;
      nrn_cnt   <= '0;
    end else begin
      // A new neuron may land in S in the same cycle S drains into O.
      if (accept && last_beat) begin
        s_valid <= 1'b1;
        s_q     <= s_d;
      end else if (o_load) begin
        s_valid <= 1'b0;
      end

      if (o_load) begin
        out_valid <= 1'b1;
        o_sat     <= s_q.sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready)
        nrn_cnt <= (nrn_cnt == NW'(n - 1)) ? '0 : nrn_cnt + 1'b1;
    end
  end

  logic [width-1:0] act_q, adot_q;

  act_unit #(.width(width), .frac_bits(frac_bits)) u_act (
    .clk    (clk),
    .enable (o_load),
    .s      (s_q.s),
    .act    (act_q),
    .adot   (adot_q)
  );

  // The lookup registers carry no reset; masking keeps the outputs at zero
  // whenever stage O is empty.
  assign act_out  = out_valid ? act_q  : '0;
  assign adot_out = out_valid ? adot_q : '0;
  assign out_sat  = o_sat;
  assign out_last = out_valid && (nrn_cnt == NW'(n - 1));

endmodule

// File: tb/tb_ff_pipe_processor.sv
// Randomized self-checking bench for ff_pipe_processor (width 16, Q5.10, z=4, fi=8, n=8).
module tb_ff_pipe_processor;

  localparam int W = 16, FB = 10, Z = 4, FI = 8, N = 8, BEATS = FI / Z, TOL = 24;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W*Z-1:0] act_in_package = '0;
  logic [W*Z-1:0] wt_package = '0;
  logic [W-1:0]   bias = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   act_out, adot_out;
  logic           out_sat, out_last;

  ff_pipe_processor #(.width(W), .int_bits(5), .frac_bits(FB), .z(Z), .fi(FI), .n(N)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .act_in_package(act_in_package), .wt_package(wt_package), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .act_out(act_out), .adot_out(adot_out),
    .out_sat(out_sat), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int s; bit sat; } exp_t;
  typedef int vec_t[FI];

  exp_t exp_q[$];
  int   tput_cyc[$];
  int   n_chk = 0, n_pass = 0;
  int   out_idx = 0, blk_cnt = 0;
  int   rdy_mode = 0;   // 0: ready high, 1: random, 2: held low
  bit   tput_on = 1'b0;

  task automatic chk(input string tag, input longint obs, input longint req);
    n_chk++;
    if (obs == req) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, req);
  endtask

  // ---------------- reference model ----------------
  function automatic int clip16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic exp_t model(input vec_t a, input vec_t w, input int b);
    exp_t   e;
    longint sum = b;
    for (int i = 0; i < FI; i++)
      sum += clip16((longint'(a[i]) * longint'(w[i])) >>> FB);
    e.s   = clip16(sum);
    e.sat = (longint'(e.s) != sum);
    return e;
  endfunction

  task automatic check_out(input exp_t e);
`ifdef ACT_RELU_EN
    chk("act_relu",  longint'(act_out),  (e.s > 0) ? e.s : 0);
    chk("adot_relu", longint'(adot_out), (e.s > 0) ? 1024 : 0);
`else
    real x, sg, ia, id, da, dd;
    if (e.s == 0) begin
      chk("act_s0",  longint'(act_out),  512);
      chk("adot_s0", longint'(adot_out), 256);
    end else begin
      x  = real'(e.s) / 1024.0;
      sg = 1.0 / (1.0 + $exp(-x));
      ia = sg * 1024.0;
      id = sg * (1.0 - sg) * 1024.0;
      da = real'(act_out) - ia;  if (da < 0) da = -da;
      dd = real'(adot_out) - id; if (dd < 0) dd = -dd;
      chk($sformatf("act_near s=%0d act=%0d ideal=%0d", e.s, act_out, int'(ia)), longint'(da <= TOL), 1);
      chk($sformatf("adot_near s=%0d adot=%0d ideal=%0d", e.s, adot_out, int'(id)), longint'(dd <= TOL), 1);
    end
`endif
    chk("out_sat", longint'(out_sat), longint'(e.sat));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset_n) begin
      exp_q.delete();
      out_idx = 0;
    end else begin
      if (!in_ready) blk_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_out(e);
        end
        chk($sformatf("out_last idx=%0d", out_idx), longint'(out_last), longint'((out_idx % N) == N - 1));
        if (tput_on) tput_cyc.push_back(cyc);
        out_idx++;
      end
    end
  end

  always begin : rdy_drv
    @(posedge clk); #1;
    case (rdy_mode)
      1:       out_ready = ($urandom_range(0, 9) < 7);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // ---------------- drivers (called at posedge+1 phase) ----------------
  task automatic drive_beat(input vec_t a, input vec_t w, input int b, input int bt);
    bit ok = 1'b0;
    for (int k = 0; k < Z; k++) begin
      act_in_package[W*k +: W] = W'(a[bt*Z + k]);
      wt_package[W*k +: W]     = W'(w[bt*Z + k]);
    end
    bias     = (bt == 0) ? W'(b) : W'($urandom);
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_neuron(input vec_t a, input vec_t w, input int b);
    for (int bt = 0; bt < BEATS; bt++) drive_beat(a, w, b, bt);
    exp_q.push_back(model(a, w, b));
  endtask

  task automatic send_fill(input int av, input int wv, input int b);
    vec_t a, w;
    for (int i = 0; i < FI; i++) begin a[i] = av; w[i] = wv; end
    send_neuron(a, w, b);
  endtask

  task automatic send_rand(input int cnt);
    vec_t a, w;
    for (int j = 0; j < cnt; j++) begin
      for (int i = 0; i < FI; i++) begin
        a[i] = int'($urandom_range(0, 2047)) - 1024;
        w[i] = int'($urandom_range(0, 2047)) - 1024;
      end
      send_neuron(a, w, int'($urandom_range(0, 4095)) - 2048);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_in_reset", longint'(in_ready), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_act",       longint'(act_out), 0);
    chk("rst_adot",      longint'(adot_out), 0);
    chk("rst_sat",       longint'(out_sat), 0);
    chk("rst_last",      longint'(out_last), 0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    vec_t ga, gw;
    int   b0, i0;

    do_reset();

    // zero products: s = 0, latency 2
    send_fill(16'h0400, 0, 0);
    @(negedge clk);
    chk("lat_cycle1_valid", longint'(out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2_valid", longint'(out_valid), 1);
    drain();

    // saturation both ways
    send_fill(16'h0400, 32767, 32767);
    send_fill(16'h0400, -32768, 32767);
    // ReLU corner values (also valid sigmoid points)
    send_fill(16'h0400, 0, -1024);
    send_fill(16'h0400, 0, 16'h0800);
    drain();

    // stall output for 10 cycles over 3 neurons
    rdy_mode = 2;
    @(posedge clk); #2;
    b0 = blk_cnt;
    i0 = out_idx;
    fork
      send_rand(3);
      begin repeat (10) @(posedge clk); rdy_mode = 0; end
    join
    drain();
    chk("stall_blocked", longint'(blk_cnt > b0), 1);
    chk("stall_count", out_idx - i0, 3);

    // partial neuron discarded by reset
    for (int i = 0; i < FI; i++) begin ga[i] = 1024; gw[i] = 32767; end
    drive_beat(ga, gw, 16'h7000, 0);
    do_reset();
    send_fill(512, 512, 100);
    drain();

    // 16 back-to-back neurons after reset
    do_reset();
    tput_cyc.delete();
    tput_on = 1'b1;
    send_rand(16);
    drain();
    tput_on = 1'b0;
    chk("tput_outputs", tput_cyc.size(), 16);
    for (int i = 1; i < tput_cyc.size(); i++)
      chk($sformatf("tput_gap%0d", i), tput_cyc[i] - tput_cyc[i-1], 2);

    // random backpressure
    rdy_mode = 1;
    send_rand(24);
    rdy_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
